debounce_array: RTL and testbench
=================================

# debounce_array

Multi-channel, parametrised key debouncer for the Morse keyer front end. It replaces the single-button debouncer. Each channel synchronises a raw button input, filters it against a programmable stability count, and produces a clean level, one-cycle press and release strobes, and an optional long-press strobe. The long-press strobe lets the Morse decoder separate dot from dash without its own timers. All channels share one clock, one reset and one sample-enable tick.

## Interface
Parameters:
- `CHANNELS`, default 4: number of independent button channels, ≥1.
- `CNT_W`, default 9: width of the per-channel stability counter.
- `STABLE_CNT`, default 31: consecutive disagreeing ticks needed to flip `level`. Range 1..2^CNT_W−1.
- `LONG_W`, default 16: width of the per-channel hold counter. Used only with the long-press feature.
- `LONG_CNT`, default 1000: ticks `level` must stay high before `long_press` fires. Range 1..2^LONG_W−1.

Ports:
- `clk` in 1: single system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `tick` in 1: sample enable. Counters advance only when `tick`=1. Tie high to count raw clocks.
- `btn0` in CHANNELS: raw, asynchronous, active-high button inputs.
- `level` out CHANNELS: debounced button state.
- `press` out CHANNELS: one-cycle strobe on a debounced 0→1 transition.
- `release` out CHANNELS: one-cycle strobe on a debounced 1→0 transition.
- `long_press` out CHANNELS: one-cycle strobe when a hold reaches `LONG_CNT`. Tied to 0 when the feature is compiled out.

## Operation
Every channel is independent and identical. There is no cross-channel interaction.
- Synchroniser: two flops, `sync1` then `sync2`, clocked every `clk` regardless of `tick`. Both reset to 0.
- Stability counter `cnt`, updated only on cycles with `tick`=1:
  - `sync2`==`level`: `cnt`←0.
  - `sync2`≠`level` and `cnt`==`STABLE_CNT`−1: `level`←`sync2`, `cnt`←0, and the matching strobe registers 1.
  - `sync2`≠`level` otherwise: `cnt`←`cnt`+1.
- With `tick`=0 the counter holds its value, `level` holds, and the strobes register 0.
- A single agreeing tick restarts the count. Bounces shorter than `STABLE_CNT` ticks never reach `level`.
- `press` and `release` are registered in the same edge that updates `level`. A strobe is high exactly during the first cycle of the new `level` value. `press` and `release` are never both high.
- Long press (feature enabled):
  - Hold counter `hold` clears whenever `level`=0.
  - On each tick with `level`=1, `hold` increments, saturating at `LONG_CNT`.
  - `long_press` pulses for one cycle on the tick where `hold` goes from `LONG_CNT`−1 to `LONG_CNT`.
  - At most one `long_press` per hold. The next one requires a release and a new press.
  - The `press` of that hold has always fired earlier.
- Reset: `sync1`, `sync2`, `cnt`, `hold`, `level`, `press`, `release` and `long_press` all go to 0.
  - Reset mid-count discards the count. No strobe is emitted during or because of reset.
  - A button held through reset produces a fresh `press` after the normal latency.

## Timing
- Latency with `tick` tied high: `btn0` goes high and stays high, set up before edge E. `press` and the new `level` appear after edge E+`STABLE_CNT`+1, which is `STABLE_CNT`+2 cycles. Release latency is the same.
- With a gated `tick`: the latency is 2 clocks plus `STABLE_CNT` ticks.
- Long-press strobe follows `press` by exactly `LONG_CNT` ticks.
- Strobe width is always exactly 1 `clk` cycle, independent of `tick` rate.
- There is no backpressure. Consumers must sample strobes every cycle.

## Configuration
- Macro: `DEBOUNCE_LONG_PRESS_EN`.
- Defined: the `hold` counters and the `long_press` logic are built, and `LONG_W`/`LONG_CNT` are honoured.
- Undefined: no hold counters are built, `long_press` is driven constant 0, and `LONG_W`/`LONG_CNT` are ignored. The port list is unchanged so integration does not vary with the macro.

## Structure
- Package `debounce_pkg` holds:
  - default constants `DEB_STABLE_CNT_DEF`=31 and `DEB_LONG_CNT_DEF`=1000;
  - edge-event encoding constants (none/press/release), used internally by the channel.
- Sub-module `debounce_channel` contains the synchroniser, stability counter, `level` register, strobes and optional hold counter for one channel.
- The top level is a generate loop instantiating `CHANNELS` copies, plus the port slicing.

## Test plan
Configuration for all scenarios: `CHANNELS`=4, `STABLE_CNT`=4, `LONG_CNT`=10, macro defined, `tick`=1 unless stated.
- Reset check: assert `reset` for 3 cycles with `btn0`=4'b1111 → all outputs 0 during reset. After release, `press`=4'b1111 pulses once, 6 cycles after `reset` falls.
- Clean press: `btn0[0]` 0→1 before edge E, held → `press[0]` high only in the cycle after E+5, and `level[0]`=1 from then. `btn0[0]` 1→0 gives the same timing on `release[0]`.
- Bounce rejection: toggle `btn0[1]` every 2 cycles for 30 cycles, then hold 0 → `level[1]`, `press[1]` and `release[1]` stay 0 throughout.
- Long press: hold `btn0[2]`=1 for 25 cycles → `press[2]` once, then `long_press[2]` exactly once, 10 cycles later. Release then re-press → a second `long_press[2]`.
- Tick gating and reset: `tick` high every 3rd cycle, with `btn0[3]`=1 → `press[3]` after 2 clocks plus 4 ticks. Repeat with `reset` pulsed after 2 ticks → no strobe, and counting restarts from 0.
- Macro off: rerun the long-press scenario → `long_press` stays 4'b0000, and `press`/`release` timing is identical.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults and edge-event encoding for the debouncer
package debounce_pkg;

    localparam int DEB_STABLE_CNT_DEF = 31;
    localparam int DEB_LONG_CNT_DEF   = 1000;

    typedef enum logic [1:0] {
        EDGE_NONE    = 2'd0,
        EDGE_PRESS   = 2'd1,
        EDGE_RELEASE = 2'd2
    } edge_ev_t;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounced key channel; long-press hold counter under DEBOUNCE_LONG_PRESS_EN
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int CNT_W      = 9,
    parameter int STABLE_CNT = DEB_STABLE_CNT_DEF,
    parameter int LONG_W     = 16,
    parameter int LONG_CNT   = DEB_LONG_CNT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn,
    output logic level,
    output logic press,
    output logic released,
    output logic long_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_next;
    edge_ev_t         ev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Any agreeing tick restarts the run, so only an unbroken disagreement flips level.
    always_comb begin
        cnt_next   = cnt;
        level_next = level;
        ev         = EDGE_NONE;
        if (tick) begin
            if (sync2 == level) begin
                cnt_next = '0;
            end else if (cnt == CNT_LAST) begin
                cnt_next   = '0;
                level_next = sync2;
                ev         = sync2 ? EDGE_PRESS : EDGE_RELEASE;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            level    <= level_next;
            press    <= (ev == EDGE_PRESS);
            released <= (ev == EDGE_RELEASE);
        end
    end

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [LONG_W-1:0] HOLD_MAX = LONG_W'(LONG_CNT);

    logic [LONG_W-1:0] hold;

    // Saturating at HOLD_MAX is what limits long_press to one pulse per hold.
    always_ff @(posedge clk) begin
        if (reset || !level) begin
            hold       <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (tick && hold != HOLD_MAX) begin
                hold       <= hold + LONG_W'(1);
                long_press <= (hold == HOLD_MAX - LONG_W'(1));
            end
        end
    end
`else
    logic unused_long_cfg;
    assign unused_long_cfg = (LONG_W > 0) ^ (LONG_CNT > 0);
    assign long_press      = 1'b0;
`endif

endmodule

// File: rtl/debounce_array.sv
// rtl/debounce_array.sv - multi-channel key debouncer top; long press enabled by DEBOUNCE_LONG_PRESS_EN
module debounce_array
    import debounce_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int CNT_W      = 9,
    parameter int STABLE_CNT = DEB_STABLE_CNT_DEF,
    parameter int LONG_W     = 16,
    parameter int LONG_CNT   = DEB_LONG_CNT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [CHANNELS-1:0] btn0,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] long_press
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .CNT_W      (CNT_W),
            .STABLE_CNT (STABLE_CNT),
            .LONG_W     (LONG_W),
            .LONG_CNT   (LONG_CNT)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .btn        (btn0[i]),
            .level      (level[i]),
            .press      (press[i]),
            .released   (released[i]),
            .long_press (long_press[i])
        );
    end

endmodule

// File: tb/tb_debounce_array.sv
// tb/tb_debounce_array.sv - directed plus randomized bench for debounce_array against a behavioural model
module tb_debounce_array;

    localparam int CH     = 4;
    localparam int STABLE = 4;
    localparam int LONG   = 10;
`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int LONG_EXP = 1;
`else
    localparam int LONG_EXP = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic [CH-1:0] btn0;
    logic [CH-1:0] level, press, released, long_press;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: filter input delayed two clocks, disagreement run length, ticks held high.
    logic [CH-1:0] m_d1, m_d2, m_level, m_press, m_rel, m_long;
    int            m_run[CH];
    int            m_held[CH];

    debounce_array #(
        .CHANNELS   (CH),
        .CNT_W      (9),
        .STABLE_CNT (STABLE),
        .LONG_W     (16),
        .LONG_CNT   (LONG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .btn0       (btn0),
        .level      (level),
        .press      (press),
        .released   (released),
        .long_press (long_press)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic t, input logic [CH-1:0] b);
        logic [CH-1:0] seen;
        logic          old;
        if (r) begin
            m_d1 = '0; m_d2 = '0; m_level = '0;
            m_press = '0; m_rel = '0; m_long = '0;
            for (int c = 0; c < CH; c++) begin
                m_run[c]  = 0;
                m_held[c] = 0;
            end
        end else begin
            seen = m_d2;
            m_d2 = m_d1;
            m_d1 = b;
            m_press = '0; m_rel = '0; m_long = '0;
            for (int c = 0; c < CH; c++) begin
                old = m_level[c];
                if (t) begin
                    if (seen[c] == old) begin
                        m_run[c] = 0;
                    end else begin
                        m_run[c]++;
                        if (m_run[c] == STABLE) begin
                            m_run[c]   = 0;
                            m_level[c] = seen[c];
                            if (seen[c]) m_press[c] = 1'b1;
                            else         m_rel[c]   = 1'b1;
                        end
                    end
                    if (old && LONG_EXP == 1 && m_held[c] < LONG) begin
                        m_held[c]++;
                        if (m_held[c] == LONG) m_long[c] = 1'b1;
                    end
                end
                if (!old) m_held[c] = 0;
            end
        end
    endtask

    task automatic step();
        logic          r, t;
        logic [CH-1:0] b;
        r = reset; t = tick; b = btn0;
        @(posedge clk);
        model_update(r, t, b);
        #1;
        chk("level", level, m_level);
        chk("press", press, m_press);
        chk("release", released, m_rel);
        chk("long_press", long_press, m_long);
        chk("press_and_release", press & released, '0);
    endtask

    initial begin
        int lat, cnt_p, cnt_l, t_p, t_l, seen, k;

        // Reset with all buttons held
        reset = 1'b1; tick = 1'b1; btn0 = 4'b1111;
        repeat (3) begin
            step();
            chk("reset_quiet", level | press | released | long_press, 4'b0000);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("reset_press_after_6", press, 4'b1111);
        step();
        chk("reset_press_once", press, 4'b0000);

        btn0 = '0;
        repeat (12) step();

        // Clean press and release on channel 0
        btn0[0] = 1'b1;
        lat = 0;
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            step();
            if (press[0]) lat = i;
        end
        chk_int("press0_latency", lat, STABLE + 2);
        repeat (5) step();
        chk("level0_held", level & 4'b0001, 4'b0001);
        btn0[0] = 1'b0;
        lat = 0;
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            step();
            if (released[0]) lat = i;
        end
        chk_int("release0_latency", lat, STABLE + 2);
        repeat (5) step();

        // Bounce rejection on channel 1
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) btn0[1] = ~btn0[1];
            step();
            if (level[1] | press[1] | released[1]) seen++;
        end
        btn0[1] = 1'b0;
        repeat (10) begin
            step();
            if (level[1] | press[1] | released[1]) seen++;
        end
        chk_int("bounce_quiet", seen, 0);

        // Long press on channel 2, twice
        for (int rep = 0; rep < 2; rep++) begin
            btn0[2] = 1'b1;
            cnt_p = 0; cnt_l = 0; t_p = -1; t_l = -1;
            for (int i = 0; i < 25; i++) begin
                step();
                if (press[2])      begin cnt_p++; t_p = i; end
                if (long_press[2]) begin cnt_l++; t_l = i; end
            end
            chk_int("long_press_count", cnt_l, LONG_EXP);
            chk_int("press_count_in_hold", cnt_p, 1);
            chk_int("press_time_in_hold", t_p, STABLE + 1);
            if (LONG_EXP == 1) chk_int("long_gap", t_l - t_p, LONG);
            btn0[2] = 1'b0;
            repeat (15) step();
        end

        // Tick every third clock on channel 3
        btn0[3] = 1'b1;
        lat = 0; k = 0;
        while (lat == 0 && k < 60) begin
            tick = (k % 3 == 0);
            step();
            k++;
            if (press[3]) lat = k;
        end
        chk_int("gated_press_latency", lat, 13);
        tick = 1'b1;
        btn0[3] = 1'b0;
        repeat (12) step();

        // Gated tick with a reset pulse after two counted ticks
        btn0[3] = 1'b1;
        cnt_p = 0; seen = 0;
        for (k = 0; k < 45; k++) begin
            tick  = (k % 3 == 0);
            reset = (k == 7);
            step();
            if (press[3]) begin
                cnt_p++;
                if (k < 21) seen++;
            end
        end
        reset = 1'b0;
        chk_int("reset_restart_press_count", cnt_p, 1);
        chk_int("reset_no_early_press", seen, 0);
        tick = 1'b1;
        btn0 = '0;
        repeat (12) step();

        // Randomized stretch: slow random toggles, random tick, rare reset
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 7) == 0) btn0[c] = ~btn0[c];
            tick  = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
